clk_div_gen: RTL and testbench

//  Synchronous, runtime-programmable clock divider / tick generator.

---
 rtl/clk_div_gen_if.sv | 43 ++++
 rtl/clk_div_gen.sv | 152 +++++++++++++++
 tb/tb_clk_div_gen.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control/status bundle of the programmable clock divider
//
// Purpose: groups the enable, divisor-load handshake and divided outputs of
//          clk_div_gen so a controller (master) and the divider (slave) share one port.
// Signals (named from the divider's point of view):
//   en_i        count enable
//   div_i       requested divisor, sampled with div_ld_i
//   div_ld_i    single-cycle divisor load request
//   div_ack_o   pulse: new divisor in effect
//   div_err_o   pulse: load rejected (div_i < 2)
//   tick_o      one-cycle strobe per period
//   clk_o       divided square-wave level
//   tick_cnt_o  tick counter, present only with CLK_DIV_TICK_CNT_EN defined
interface clk_div_gen_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic [CNT_W-1:0] div_i;
  logic             div_ld_i;
  logic             div_ack_o;
  logic             div_err_o;
  logic             tick_o;
  logic             clk_o;
`ifdef CLK_DIV_TICK_CNT_EN
  logic [31:0]      tick_cnt_o;
`endif

  modport master (
    output en_i, div_i, div_ld_i,
`ifdef CLK_DIV_TICK_CNT_EN
    input  tick_cnt_o,
`endif
    input  div_ack_o, div_err_o, tick_o, clk_o
  );

  modport slave (
    input  en_i, div_i, div_ld_i,
`ifdef CLK_DIV_TICK_CNT_EN
    output tick_cnt_o,
`endif
    output div_ack_o, div_err_o, tick_o, clk_o
  );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - runtime-programmable clock divider / tick generator
//
// Purpose: divides clk_i by a programmable N (>= 2) using a single counter on
//          clk_i. Produces a square-wave enable level (clk_o, low floor(N/2) and
//          high N-floor(N/2) enabled cycles) and a one-cycle tick per period.
//          New divisors are held pending and applied at the next period
//          boundary, or immediately while the divider is disabled.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high
//   bus    clk_div_gen_if.slave: en_i, div_i, div_ld_i, div_ack_o,
//          div_err_o, tick_o, clk_o (and tick_cnt_o, see below)
// Configuration:
//   CLK_DIV_TICK_CNT_EN  when defined, adds bus.tick_cnt_o, a 32-bit count of
//                        tick pulses cleared by reset and by each div_ack_o.
module clk_div_gen #(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clk_div_gen_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_q,   div_d;
  logic [CNT_W-1:0] pend_q,  pend_d;
  logic             tick_q,  tick_d;
  logic             clk_q,   clk_d;
  logic             ack_q,   ack_d;
  logic             err_q,   err_d;

  logic             ld_ok;
  logic             ld_bad;
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;

  assign ld_ok   = bus.div_ld_i && (bus.div_i >= TWO);
  assign ld_bad  = bus.div_ld_i && (bus.div_i < TWO);
  // div_q is always >= 2, so div_q-1 never underflows and cnt_q+1 below
  // never exceeds div_q-1.
  assign wrap    = bus.en_i && (cnt_q == div_q - ONE);
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    clk_d   = clk_q;
    ack_d   = 1'b0;
    err_d   = ld_bad;

    if (!bus.en_i) begin
      // Frozen divider: nothing to preserve, so a new or pending divisor is
      // applied at once and the period restarts from zero.
      if (ld_ok || (state_q == ST_PEND)) begin
        div_d   = ld_ok ? bus.div_i : pend_q;
        cnt_d   = '0;
        clk_d   = 1'b0;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      // cnt 0 is below div>>1 for every legal divisor, so clk_o always falls here.
      clk_d  = 1'b0;
      if (ld_ok) begin
        // Load coinciding with the boundary bypasses pend; older pend is dropped.
        div_d   = bus.div_i;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (state_q == ST_PEND) begin
        div_d   = pend_q;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc >= (div_q >> 1));
      if (ld_ok) begin
        pend_d  = bus.div_i;
        state_d = ST_PEND;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_RST_C;
      pend_q  <= '0;
      tick_q  <= 1'b0;
      clk_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      clk_q   <= clk_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.tick_o    = tick_q;
  assign bus.clk_o     = clk_q;
  assign bus.div_ack_o = ack_q;
  assign bus.div_err_o = err_q;

`ifdef CLK_DIV_TICK_CNT_EN
  logic [31:0] tick_cnt_q, tick_cnt_d;

  // Cleared on the edge that raises div_ack_o, so the count reads 0 while the
  // ack is visible and counts ticks of the new divisor only.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (ack_d) begin
      tick_cnt_d = '0;
    end else if (tick_d) begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bus.tick_cnt_o = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - self-checking bench for clk_div_gen
module tb_clk_div_gen;

  logic clk;
  logic rst;

  clk_div_gen_if #(.CNT_W(16)) if0 ();

  clk_div_gen #(
    .CNT_W  (16),
    .DIV_RST(4096)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] div;
    logic        tick;
    logic        clko;
    logic        ack;
    logic        err;
  } vec_t;

  typedef struct {
    int len;
    int lo;
    int hi;
  } per_t;

  vec_t vt[23];
  per_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen = 0;
  int err_seen = 0;
  int run_len = 0;
  int run_lo = 0;
  int run_hi = 0;
  bit mon_on = 1'b0;
  int base;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int len, input int lo, input int hi);
    per_t p;
    p.len = len;
    p.lo  = lo;
    p.hi  = hi;
    exp_q.push_back(p);
  endtask

  task automatic set_v(input int i, input logic en, input logic ld, input int div,
                       input logic tk, input logic ck, input logic ak, input logic er);
    vt[i].en   = en;
    vt[i].ld   = ld;
    vt[i].div  = 16'(div);
    vt[i].tick = tk;
    vt[i].clko = ck;
    vt[i].ack  = ak;
    vt[i].err  = er;
  endtask

  task automatic apply_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if0.en_i     = vt[i].en;
      if0.div_ld_i = vt[i].ld;
      if0.div_i    = vt[i].div;
      @(negedge clk);
      check($sformatf("v%0d_tick", i), int'(if0.tick_o),    int'(vt[i].tick));
      check($sformatf("v%0d_clk", i),  int'(if0.clk_o),     int'(vt[i].clko));
      check($sformatf("v%0d_ack", i),  int'(if0.div_ack_o), int'(vt[i].ack));
      check($sformatf("v%0d_err", i),  int'(if0.div_err_o), int'(vt[i].err));
    end
    if0.div_ld_i = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.tick_o && n < limit);
    check(name, int'(if0.tick_o), 1);
  endtask

  // Period scoreboard: measures every tick-to-tick interval (length, clk_o
  // low/high cycles) and compares it with the next expected record.
  always begin
    @(posedge clk);
    #1;
    if (if0.div_ack_o) ack_seen++;
    if (if0.div_err_o) err_seen++;
    if (!mon_on) begin
      run_len = 0;
      run_lo  = 0;
      run_hi  = 0;
    end else begin
      run_len++;
      if (if0.clk_o) run_hi++;
      else run_lo++;
      if (if0.tick_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL period_extra: got period %0d, expected none", run_len);
        end else begin
          per_t p;
          p = exp_q.pop_front();
          check("period_len", run_len, p.len);
          check("period_lo",  run_lo,  p.lo);
          check("period_hi",  run_hi,  p.hi);
        end
        run_len = 0;
        run_lo  = 0;
        run_hi  = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T3: invalid loads (div 4096, starting at cnt 0)
    set_v(0,  1, 1, 1, 0, 0, 0, 1);
    set_v(1,  1, 0, 0, 0, 0, 0, 0);
    set_v(2,  1, 1, 0, 0, 0, 0, 1);
    set_v(3,  1, 0, 0, 0, 0, 0, 0);
    // div 5 steady state, two periods from cnt 0
    for (int p = 0; p < 2; p++) begin
      set_v(4 + 5*p, 1, 0, 0, 0, 0, 0, 0);
      set_v(5 + 5*p, 1, 0, 0, 0, 1, 0, 0);
      set_v(6 + 5*p, 1, 0, 0, 0, 1, 0, 0);
      set_v(7 + 5*p, 1, 0, 0, 0, 1, 0, 0);
      set_v(8 + 5*p, 1, 0, 0, 1, 0, 0, 0);
    end
    // Disable / hold / load while disabled, then period 3
    set_v(14, 0, 0, 0, 0, 0, 0, 0);
    set_v(15, 1, 0, 0, 0, 0, 0, 0);
    set_v(16, 1, 0, 0, 0, 1, 0, 0);
    set_v(17, 0, 0, 0, 0, 1, 0, 0);
    set_v(18, 0, 0, 0, 0, 1, 0, 0);
    set_v(19, 0, 1, 3, 0, 0, 1, 0);
    set_v(20, 1, 0, 0, 0, 1, 0, 0);
    set_v(21, 1, 0, 0, 0, 1, 0, 0);
    set_v(22, 1, 0, 0, 1, 0, 0, 0);

    rst = 1'b1;
    if0.en_i = 1'b0;
    if0.div_ld_i = 1'b0;
    if0.div_i = '0;
    adv(3);
    check("rst_tick", int'(if0.tick_o), 0);
    check("rst_clk",  int'(if0.clk_o), 0);
    check("rst_ack",  int'(if0.div_ack_o), 0);
    check("rst_err",  int'(if0.div_err_o), 0);
`ifdef CLK_DIV_TICK_CNT_EN
    check("rst_tick_cnt", int'(if0.tick_cnt_o), 0);
`endif

    // T1: default divisor
    rst = 1'b0;
    if0.en_i = 1'b1;
    mon_on = 1'b1;
    push(4096, 2048, 2048);
    push(4096, 2048, 2048);
    wait_tick("t1_tick_a", 5000);
    wait_tick("t1_tick_b", 5000);
`ifdef CLK_DIV_TICK_CNT_EN
    check("t1_tick_cnt", int'(if0.tick_cnt_o), 2);
`endif

    // T3: rejected loads leave the period alone
    base = ack_seen;
    push(4096, 2048, 2048);
    apply_range(0, 3);
    wait_tick("t3_tick", 5000);
    check("t3_ack_count", ack_seen - base, 0);
    check("t3_err_count", err_seen, 2);

    // T4a: pause 10 cycles at cnt 7
    push(4106, 2058, 2048);
    adv(7);
    if0.en_i = 1'b0;
    @(negedge clk);
    check("t4_hold_tick", int'(if0.tick_o), 0);
    check("t4_hold_clk",  int'(if0.clk_o), 0);
    adv(9);
    if0.en_i = 1'b1;
    wait_tick("t4_tick", 5000);

    // T6: reset at cnt 2000 with a load pending
    mon_on = 1'b0;
    base = ack_seen;
    adv(1990);
    if0.div_ld_i = 1'b1;
    if0.div_i = 16'd5;
    @(negedge clk);
    if0.div_ld_i = 1'b0;
    adv(9);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tick", int'(if0.tick_o), 0);
    check("t6_clk",  int'(if0.clk_o), 0);
    check("t6_ack",  int'(if0.div_ack_o), 0);
    check("t6_err",  int'(if0.div_err_o), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    push(4096, 2048, 2048);
    wait_tick("t6_tick_after", 5000);
    check("t6_ack_at_wrap", int'(if0.div_ack_o), 0);
    check("t6_ack_count", ack_seen - base, 0);

    // T2: load 5 at cnt 100, applied at the boundary
    base = ack_seen;
    push(4096, 2048, 2048);
    adv(100);
    if0.div_ld_i = 1'b1;
    if0.div_i = 16'd5;
    @(negedge clk);
    if0.div_ld_i = 1'b0;
    check("t2_ack_early", int'(if0.div_ack_o), 0);
    wait_tick("t2_tick", 5000);
    check("t2_ack", int'(if0.div_ack_o), 1);
    check("t2_ack_count", ack_seen - base, 1);
`ifdef CLK_DIV_TICK_CNT_EN
    check("t2_tick_cnt_clr", int'(if0.tick_cnt_o), 0);
`endif
    push(5, 2, 3);
    push(5, 2, 3);
    apply_range(4, 13);

    // T4b: freeze, hold, immediate load of 3
    mon_on = 1'b0;
    apply_range(14, 19);
    mon_on = 1'b1;
    push(3, 1, 2);
    apply_range(20, 22);

    // T5: last load wins, then bypass load at the wrap edge
    base = ack_seen;
    push(3, 1, 2);
    push(9, 4, 5);
    push(9, 4, 5);
    push(7, 3, 4);
    push(7, 3, 4);
    if0.div_ld_i = 1'b1;
    if0.div_i = 16'd6;
    @(negedge clk);
    if0.div_i = 16'd9;
    @(negedge clk);
    if0.div_ld_i = 1'b0;
    wait_tick("t5_tick_a", 20);
    check("t5_ack_a", int'(if0.div_ack_o), 1);
    wait_tick("t5_tick_b", 20);
    check("t5_ack_b", int'(if0.div_ack_o), 0);
    adv(8);
    check("t5_clk_cnt8", int'(if0.clk_o), 1);
    if0.div_ld_i = 1'b1;
    if0.div_i = 16'd7;
    @(negedge clk);
    if0.div_ld_i = 1'b0;
    check("t5_bypass_tick", int'(if0.tick_o), 1);
    check("t5_bypass_ack",  int'(if0.div_ack_o), 1);
    wait_tick("t5_tick_c", 20);
    wait_tick("t5_tick_d", 20);
    check("t5_ack_count", ack_seen - base, 2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
